// File: rtl/game_button_conditioner_pkg.sv
// game_defs: definitions shared by the game FSM and its button conditioner.
//   game_state_t     : FSM state codes
//   BTN_*            : bit positions of the three buttons in command vectors
//   DEBOUNCE_DEFAULT : 5 ms of stability at 50 MHz
//   arbitrate()      : reduces coincident press candidates to one command
package game_defs;

  typedef enum logic [2:0] {
    START    = 3'b000,
    PLAYING  = 3'b001,
    PAUSE    = 3'b010,
    RESET    = 3'b011,
    GAMEOVER = 3'b100
  } game_state_t;

  localparam int BTN_START = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_RESET = 2;
  localparam int BTN_COUNT = 3;

  localparam int DEBOUNCE_DEFAULT = 250000;

  // Restart beats pause beats start; losers are simply dropped so the FSM
  // never sees two commands in one cycle.
  function automatic logic [BTN_COUNT-1:0] arbitrate(input logic [BTN_COUNT-1:0] cand);
    logic [BTN_COUNT-1:0] grant;
    grant = '0;
    if (cand[BTN_RESET])      grant[BTN_RESET] = 1'b1;
    else if (cand[BTN_PAUSE]) grant[BTN_PAUSE] = 1'b1;
    else if (cand[BTN_START]) grant[BTN_START] = 1'b1;
    return grant;
  endfunction

endpackage

// File: rtl/game_button_conditioner_debounce.sv
// button_debounce: conditions one raw push-button into a single-cycle press
// candidate.
//   clk         : system clock
//   resetFSM    : synchronous active-high reset; clears every stage
//   btn_raw     : raw asynchronous, bouncing button level
//   press_pulse : high for one cycle when the debounced level becomes pressed
module button_debounce
  import game_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic resetFSM,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic              RAW_IDLE = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             pressed_p1;
  logic [CNT_W-1:0] cnt;
  logic             stable_p2;
  logic             stable_p3;

  // Stage p0/p1: two-flop synchroniser; reset parks it at the released level
  // so a button held through reset is later seen as a fresh press.
  always_ff @(posedge clk) begin
    if (resetFSM) begin
      sync_p0 <= RAW_IDLE;
      sync_p1 <= RAW_IDLE;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed_p1 = (ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;

  // Stage p2: debounce counter and accepted level. The count only survives
  // while every cycle disagrees with stable, and the flip happens on the
  // cycle the count would reach DEBOUNCE_CYCLES, so it never wraps.
  always_ff @(posedge clk) begin
    if (resetFSM) begin
      cnt       <= '0;
      stable_p2 <= 1'b0;
    end else if (pressed_p1 != stable_p2) begin
      if (cnt == CNT_LAST) begin
        cnt       <= '0;
        stable_p2 <= pressed_p1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Stage p3: delayed copy of stable for released->pressed edge detection.
  always_ff @(posedge clk) begin
    if (resetFSM) stable_p3 <= 1'b0;
    else          stable_p3 <= stable_p2;
  end

  assign press_pulse = stable_p2 & ~stable_p3;

endmodule

// File: rtl/game_button_conditioner.sv
// game_button_conditioner: turns the start, pause and restart push-buttons
// into clean, arbitrated, registered one-cycle commands for the game FSM.
//   clk        : system clock
//   resetFSM   : synchronous active-high system reset shared with the FSM
//   btn_start  : raw start button (asynchronous)
//   btn_pause  : raw pause button (asynchronous)
//   btn_reset  : raw restart button (asynchronous)
//   startGame  : one-cycle start command
//   pauseGame  : one-cycle pause command
//   reset      : one-cycle game-restart command
module game_button_conditioner
  import game_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic resetFSM,
  input  logic btn_start,
  input  logic btn_pause,
  input  logic btn_reset,
  output logic startGame,
  output logic pauseGame,
  output logic reset
);

  logic [BTN_COUNT-1:0] cand_p3;
  logic [BTN_COUNT-1:0] grant_p3;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_start (
    .clk        (clk),
    .resetFSM   (resetFSM),
    .btn_raw    (btn_start),
    .press_pulse(cand_p3[BTN_START])
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_pause (
    .clk        (clk),
    .resetFSM   (resetFSM),
    .btn_raw    (btn_pause),
    .press_pulse(cand_p3[BTN_PAUSE])
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_reset (
    .clk        (clk),
    .resetFSM   (resetFSM),
    .btn_raw    (btn_reset),
    .press_pulse(cand_p3[BTN_RESET])
  );

  always_comb begin
    grant_p3 = arbitrate(cand_p3);
  end

  // Stage p4: registered command outputs.
  always_ff @(posedge clk) begin
    if (resetFSM) begin
      startGame <= 1'b0;
      pauseGame <= 1'b0;
      reset     <= 1'b0;
    end else begin
      startGame <= grant_p3[BTN_START];
      pauseGame <= grant_p3[BTN_PAUSE];
      reset     <= grant_p3[BTN_RESET];
    end
  end

endmodule
